uart_tx_fifo_drain: RTL

//   Read-side consumer of the 4-entry byte FIFO in the APB UART peripheral. Pops one

---
 rtl/uart_tx_fifo_drain.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
// Read side of the UART transmit FIFO. The block pops one byte at a time from
// a first-word-fall-through FIFO and sends it on tx as an 8N1 frame: one start
// bit (low), eight data bits LSB first, and one stop bit (high). Each bit lasts
// BIT_CYCLES clocks.
//
// Timing of one frame, where a pop happens in cycle N:
//   N+1 .. N+BIT_CYCLES        start bit
//   next 8*BIT_CYCLES clocks   data bits 0..7
//   last BIT_CYCLES clocks     stop bit, with tx_done high on its final clock
//   N+10*BIT_CYCLES+1          back in IDLE; the earliest next pop happens here
//
// tx, tx_busy and tx_done come straight from flops. Their next values are
// derived from the next state, so each output changes on the same edge as the
// state it describes.
module uart_tx_fifo_drain #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int BIT_CYCLES = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  // The bit timer holds 0..BIT_CYCLES-1. It needs at least one bit even in the
  // smallest legal configuration, BIT_CYCLES = 2.
  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  // Value of the bit timer on the last clock of a bit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  // Value of the bit timer one clock before the last clock of a bit.
  // tx_done is a registered output, so it must be set on the edge that ends
  // this clock in order to be high on the final stop-bit clock.
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(BIT_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_end;
  logic             start_frame;
  logic [7:0]       shift_next;

  // Last clock of the current bit period.
  assign bit_end = (cnt_q == CNT_LAST);

  // A frame can start only from IDLE, only when enabled, and only when a byte
  // is waiting in the FIFO.
  assign start_frame = (state_q == IDLE) && tx_en && !fifo_empty;

  // Right shift of the data register. The bit that goes out next is always
  // held in bit 0. Ones are filled in at the top; they are never transmitted.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_shift
      assign shift_next[gi] = shreg_q[gi+1];
    end
  endgenerate
  assign shift_next[7] = 1'b1;

  // State register. An asynchronous reset aborts any frame in progress and
  // forces the line high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: frame sequencing, the bit timer, the data index and the
  // shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;

    case (state_q)
      IDLE: begin
        // Clear the timer and the index here so that no count carries over
        // from one frame into the next.
        cnt_d = '0;
        idx_d = '0;
        if (start_frame) begin
          state_d = START;
          shreg_d = fifo_rdata;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shreg_d = shift_next;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Output logic: the pop strobe, and the next values of the registered line
  // outputs.
  always_comb begin
    // The pop is combinational so that it lines up with the cycle in which the
    // head byte is captured. It is held low during reset, because the state
    // register shows IDLE while reset is asserted.
    fifo_rd_en = start_frame && !reset;

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (cnt_q == CNT_DONE);
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
